// File: rtl/lc3b_assoc_cache.sv
// Set-associative write-back/write-allocate cache for the LC-3b memory port.
// Flop-based arrays, combinational lookup, true-LRU ages per set.
module lc3b_assoc_cache #(
  parameter int NUM_SETS = 8,
  parameter int NUM_WAYS = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_address,
  input  logic [15:0]  mem_wdata,
  output logic         mem_resp,
  output logic [15:0]  mem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic         pmem_resp,
  input  logic [127:0] pmem_rdata
);
  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = 12 - IW;
  localparam int WW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_e;

  state_e              state_q;
  logic [NUM_SETS-1:0] valid_q [NUM_WAYS];
  logic [NUM_SETS-1:0] dirty_q [NUM_WAYS];
  logic [WW-1:0]       age_q   [NUM_WAYS][NUM_SETS];
  logic [TW-1:0]       tag_q   [NUM_WAYS][NUM_SETS];
  logic [127:0]        data_q  [NUM_WAYS][NUM_SETS];
  logic [WW-1:0]       victim_q;

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [6:0]    boff;
  logic          req, hit, found;
  logic [WW-1:0] hit_way, victim_d;

  assign idx  = mem_address[IW+3:4];
  assign tag  = mem_address[15:IW+4];
  assign boff = {mem_address[3:1], 4'h0};
  assign req  = mem_read | mem_write;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
  end

  // Lowest invalid way wins; otherwise the oldest way of the set.
  always_comb begin
    victim_d = '0;
    found    = 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!valid_q[w][idx]) begin
        victim_d = WW'(w);
        found    = 1'b1;
      end
    if (!found)
      for (int w = 0; w < NUM_WAYS; w++)
        if (age_q[w][idx] == WW'(NUM_WAYS - 1)) victim_d = WW'(w);
  end

  assign mem_resp     = (state_q == COMPARE) && req && hit;
  assign mem_rdata    = mem_resp ? data_q[hit_way][idx][boff +: 16] : 16'h0000;
  assign pmem_read    = (state_q == ALLOCATE);
  assign pmem_write   = (state_q == WRITEBACK);
  assign pmem_address = pmem_write ? {tag_q[victim_q][idx], idx, 4'h0} : {tag, idx, 4'h0};
  assign pmem_wdata   = data_q[victim_q][idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= COMPARE;
      victim_q <= '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
        for (int s = 0; s < NUM_SETS; s++) age_q[w][s] <= WW'(w);
      end
    end else begin
      case (state_q)
        COMPARE: if (req) begin
          if (hit) begin
            if (mem_write) dirty_q[hit_way][idx] <= 1'b1;
            for (int w = 0; w < NUM_WAYS; w++)
              if (age_q[w][idx] < age_q[hit_way][idx]) age_q[w][idx] <= age_q[w][idx] + 1'b1;
            age_q[hit_way][idx] <= '0;
          end else begin
            victim_q <= victim_d;
            state_q  <= dirty_q[victim_d][idx] ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: if (pmem_resp) begin
          dirty_q[victim_q][idx] <= 1'b0;
          state_q                <= ALLOCATE;
        end
        ALLOCATE: if (pmem_resp) begin
          valid_q[victim_q][idx] <= 1'b1;
          dirty_q[victim_q][idx] <= 1'b0;
          state_q                <= COMPARE;
        end
        default: state_q <= COMPARE;
      endcase
    end
  end

  // Tag/data carry no reset; state_q gates writes so a fill racing reset is dropped.
  always_ff @(posedge clk) begin
    if (state_q == COMPARE && mem_write && hit) begin
      if (mem_byte_enable[0]) data_q[hit_way][idx][boff +: 8]       <= mem_wdata[7:0];
      if (mem_byte_enable[1]) data_q[hit_way][idx][(boff + 7'd8) +: 8] <= mem_wdata[15:8];
    end
    if (state_q == ALLOCATE && pmem_resp) begin
      data_q[victim_q][idx] <= pmem_rdata;
      tag_q[victim_q][idx]  <= tag;
    end
  end
endmodule

// File: tb/tb_lc3b_assoc_cache.sv
// Scoreboard bench: dut0 is 8 sets x 2 ways, dut1 is 4 sets x 1 way.
module tb_lc3b_assoc_cache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         mem_read [2], mem_write [2], resp [2], pr [2], pw [2], presp [2];
  logic [1:0]   be [2];
  logic [15:0]  addr [2], wdata [2], rdata [2], pa [2];
  logic [127:0] pwd [2], prd [2];

  lc3b_assoc_cache #(.NUM_SETS(8), .NUM_WAYS(2)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .mem_byte_enable(be[0]), .mem_address(addr[0]), .mem_wdata(wdata[0]),
    .mem_resp(resp[0]), .mem_rdata(rdata[0]), .pmem_read(pr[0]), .pmem_write(pw[0]),
    .pmem_address(pa[0]), .pmem_wdata(pwd[0]), .pmem_resp(presp[0]), .pmem_rdata(prd[0]));

  lc3b_assoc_cache #(.NUM_SETS(4), .NUM_WAYS(1)) dut1 (
    .clk(clk), .rst(rst), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .mem_byte_enable(be[1]), .mem_address(addr[1]), .mem_wdata(wdata[1]),
    .mem_resp(resp[1]), .mem_rdata(rdata[1]), .pmem_read(pr[1]), .pmem_write(pw[1]),
    .pmem_address(pa[1]), .pmem_wdata(pwd[1]), .pmem_resp(presp[1]), .pmem_rdata(prd[1]));

  typedef struct {int d; logic chk; logic [15:0] rdata;} cpu_exp_t;
  typedef struct {int d; logic wr; logic [15:0] addr; logic chk_data; logic [127:0] data;} pm_exp_t;

  cpu_exp_t     cq[$];
  pm_exp_t      pq[$];
  logic [127:0] mem_img [int];
  int total = 0, passed = 0, cyc = 0;
  int last_presp [2], fills [2], wbs [2], cnt [2];
  logic busy [2], lat_w [2];
  logic [15:0] lat_a [2];
  logic mem_auto = 1'b1;
  int fill_delay = 3;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Backing-store content for lines never written back.
  function automatic logic [127:0] fill_line(logic [15:0] a);
    logic [127:0] l;
    for (int i = 0; i < 8; i++) l[i*16 +: 16] = {a[15:8] ^ 8'h5A, a[7:4], 4'(i)};
    if (a == 16'h0040) l[31:16] = 16'h1234;
    return l;
  endfunction

  // Physical memory responder.
  initial begin
    for (int d = 0; d < 2; d++) begin presp[d] = 1'b0; prd[d] = '0; cnt[d] = 0; end
    forever begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        if (presp[d]) begin
          presp[d] = 1'b0;
          cnt[d]   = 0;
        end else if (!(pr[d] || pw[d]) || rst) begin
          cnt[d] = 0;
        end else if (mem_auto) begin
          cnt[d]++;
          if (cnt[d] >= fill_delay) begin
            if (pw[d]) mem_img[d*65536 + int'(pa[d])] = pwd[d];
            else prd[d] = mem_img.exists(d*65536 + int'(pa[d])) ? mem_img[d*65536 + int'(pa[d])]
                                                                : fill_line(pa[d]);
            presp[d] = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: compares every DUT response against the scoreboard queues.
  initial begin
    cpu_exp_t ce;
    pm_exp_t  pe;
    for (int d = 0; d < 2; d++) begin
      busy[d] = 1'b0; lat_w[d] = 1'b0; lat_a[d] = '0; last_presp[d] = 0; fills[d] = 0; wbs[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (resp[d]) begin
          chk("cpu response expected", 128'(cq.size() > 0), 128'(1));
          if (cq.size() > 0) begin
            ce = cq.pop_front();
            chk("cpu response dut", 128'(d), 128'(ce.d));
            if (ce.chk) chk("mem_rdata", 128'(rdata[d]), 128'(ce.rdata));
          end
        end else begin
          chk("mem_rdata idle zero", 128'(rdata[d]), 128'(0));
        end
        chk("pmem read/write exclusive", 128'(pr[d] & pw[d]), 128'(0));
        if ((pr[d] || pw[d]) && !busy[d]) begin
          busy[d] = 1'b1; lat_w[d] = pw[d]; lat_a[d] = pa[d];
          if (pw[d]) wbs[d]++; else fills[d]++;
          chk("pmem request expected", 128'(pq.size() > 0), 128'(1));
          if (pq.size() > 0) begin
            pe = pq.pop_front();
            chk("pmem dut", 128'(d), 128'(pe.d));
            chk("pmem is write", 128'(pw[d]), 128'(pe.wr));
            chk("pmem_address", 128'(pa[d]), 128'(pe.addr));
            if (pe.chk_data) chk("pmem_wdata", pwd[d], pe.data);
          end
        end else if (pr[d] || pw[d]) begin
          chk("pmem request stable", 128'({pw[d], pa[d]}), 128'({lat_w[d], lat_a[d]}));
        end
        if (presp[d]) last_presp[d] = cyc;
        if (presp[d] || !(pr[d] || pw[d])) busy[d] = 1'b0;
      end
    end
  end

  // mode 1: must hit in the request cycle; mode 2: must respond the cycle after a fill.
  task automatic access(int d, logic [15:0] a, logic wr, logic [1:0] b, logic [15:0] wd,
                        logic [15:0] exp_rd, int mode);
    cpu_exp_t e;
    int n;
    e.d = d; e.chk = !wr; e.rdata = exp_rd;
    cq.push_back(e);
    addr[d] = a; mem_write[d] = wr; mem_read[d] = !wr; be[d] = b; wdata[d] = wd;
    n = 0;
    @(negedge clk);
    while (!resp[d] && n < 200) begin n++; @(negedge clk); end
    chk("response before timeout", 128'(n < 200), 128'(1));
    if (mode == 1) chk("hit latency", 128'(n), 128'(0));
    if (mode == 2) chk("fill to resp latency", 128'(cyc), 128'(last_presp[d] + 1));
    @(posedge clk); #1;
    mem_read[d] = 1'b0; mem_write[d] = 1'b0;
  endtask

  task automatic expect_pmem(int d, logic wr, logic [15:0] a, logic cd, logic [127:0] data);
    pm_exp_t p;
    p.d = d; p.wr = wr; p.addr = a; p.chk_data = cd; p.data = data;
    pq.push_back(p);
  endtask

  initial begin
    logic [127:0] wb_line;
    for (int d = 0; d < 2; d++) begin
      mem_read[d] = 1'b0; mem_write[d] = 1'b0; be[d] = '0; addr[d] = '0; wdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset mem_resp", 128'(resp[d]), 128'(0));
      chk("reset pmem_read", 128'(pr[d]), 128'(0));
      chk("reset pmem_write", 128'(pw[d]), 128'(0));
      chk("reset mem_rdata", 128'(rdata[d]), 128'(0));
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Cold miss, write hit, read-back of merged word.
    expect_pmem(0, 1'b0, 16'h0040, 1'b0, '0);
    access(0, 16'h0042, 1'b0, 2'b00, 16'h0000, 16'h1234, 2);
    access(0, 16'h0042, 1'b1, 2'b01, 16'hABCD, 16'h0000, 1);
    access(0, 16'h0042, 1'b0, 2'b00, 16'h0000, 16'h12CD, 1);

    // LRU: 0x00C0 becomes oldest and is evicted cleanly by 0x0140.
    access(0, 16'h0040, 1'b1, 2'b10, 16'hBE00, 16'h0000, 1);
    expect_pmem(0, 1'b0, 16'h00C0, 1'b0, '0);
    access(0, 16'h00C0, 1'b0, 2'b00, 16'h0000, 16'h5AC0, 2);
    access(0, 16'h0040, 1'b0, 2'b00, 16'h0000, 16'hBE40, 1);
    expect_pmem(0, 1'b0, 16'h0140, 1'b0, '0);
    access(0, 16'h0140, 1'b0, 2'b00, 16'h0000, 16'h5B40, 2);

    // Dirty eviction of the 0x0040 line.
    wb_line = fill_line(16'h0040);
    wb_line[31:16] = 16'h12CD;
    wb_line[15:0]  = 16'hBE40;
    expect_pmem(0, 1'b1, 16'h0040, 1'b1, wb_line);
    expect_pmem(0, 1'b0, 16'h00C0, 1'b0, '0);
    access(0, 16'h00C0, 1'b0, 2'b00, 16'h0000, 16'h5AC0, 2);

    // Stalled fill, then reset mid-ALLOCATE.
    mem_auto = 1'b0;
    expect_pmem(0, 1'b0, 16'h0040, 1'b0, '0);
    addr[0] = 16'h0042; mem_read[0] = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("stall pmem_read", 128'(pr[0]), 128'(1));
      chk("stall pmem_address", 128'(pa[0]), 128'(16'h0040));
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("reset drops pmem_read", 128'(pr[0]), 128'(0));
    chk("reset mem_resp low", 128'(resp[0]), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0; mem_read[0] = 1'b0; mem_auto = 1'b1;
    @(posedge clk); #1;
    expect_pmem(0, 1'b0, 16'h0040, 1'b0, '0);
    access(0, 16'h0042, 1'b0, 2'b00, 16'h0000, 16'h12CD, 2);

    // Direct-mapped configuration: conflicting lines refill every time.
    expect_pmem(1, 1'b0, 16'h0010, 1'b0, '0);
    access(1, 16'h0010, 1'b0, 2'b00, 16'h0000, 16'h5A10, 2);
    expect_pmem(1, 1'b0, 16'h0050, 1'b0, '0);
    access(1, 16'h0050, 1'b0, 2'b00, 16'h0000, 16'h5A50, 2);
    expect_pmem(1, 1'b0, 16'h0010, 1'b0, '0);
    access(1, 16'h0010, 1'b0, 2'b00, 16'h0000, 16'h5A10, 2);

    repeat (3) @(posedge clk);
    #1;
    chk("cpu queue drained", 128'(cq.size()), 128'(0));
    chk("pmem queue drained", 128'(pq.size()), 128'(0));
    chk("dut0 fills", 128'(fills[0]), 128'(6));
    chk("dut0 writebacks", 128'(wbs[0]), 128'(1));
    chk("dut1 fills", 128'(fills[1]), 128'(3));
    chk("dut1 writebacks", 128'(wbs[1]), 128'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
    $fatal(1);
  end
endmodule
